signal_debouncer: RTL and testbench
===================================

SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on rawIn; legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive agreeing synchronised samples required to accept a new level; legal range >= 1.
REQ-003 Parameter RESET_LEVEL, default 0: level loaded into the synchroniser chain and debounced during reset.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rawIn  input  1  asynchronous, bouncy source level (switch, external strobe).
REQ-007 enable  input  1  high = qualification active; low = debounced frozen.
REQ-008 clearGlitch  input  1  synchronous clear of glitchCount.
REQ-009 debounced  output  1  clean level; feeds the downstream rising-edge detector directly.
REQ-010 stable  output  1  high when no qualification is in progress.
REQ-011 glitchCount  output  8  saturating count of rejected (unqualified) transitions.

Function
REQ-012 rawIn SHALL pass through SYNC_STAGES flops in series; syncOut = last stage; no other logic samples rawIn.
REQ-013 FSM states: STABLE_LOW, QUALIFY_HIGH, STABLE_HIGH, QUALIFY_LOW; debounced = 1 exactly in STABLE_HIGH and QUALIFY_LOW.
REQ-014 Qualify counter width = clog2(DEBOUNCE_CYCLES+1); counts consecutive cycles with syncOut != debounced.
REQ-015 STABLE_x, syncOut != debounced: counter <= 1; if DEBOUNCE_CYCLES == 1, go directly to STABLE of the new level, else go to QUALIFY of the new level.
REQ-016 QUALIFY_x, syncOut still differs: counter increments; on the edge where it reaches DEBOUNCE_CYCLES, go to STABLE of the new level, counter <= 0, debounced flips on that same edge.
REQ-017 QUALIFY_x, syncOut returns to debounced: go back to STABLE of the old level, counter <= 0, glitchCount increments by 1.
REQ-018 Latency: a clean rawIn change captured by synchroniser stage 1 on edge 1 SHALL update debounced on edge SYNC_STAGES+DEBOUNCE_CYCLES, never earlier.
REQ-019 debounced SHALL change at most once per DEBOUNCE_CYCLES cycles and SHALL be glitch-free (registered, no combinational path from rawIn).
REQ-020 stable = 1 in STABLE_LOW/STABLE_HIGH, 0 in QUALIFY states.
REQ-021 enable low: FSM forced to STABLE of the current debounced level, counter <= 0, debounced held, synchroniser keeps running, no glitch counted for an abandoned qualification.
REQ-022 enable rising with syncOut != debounced: qualification starts fresh on that cycle per REQ-015.
REQ-023 glitchCount SHALL saturate at 255; further glitches leave it at 255.
REQ-024 clearGlitch high SHALL set glitchCount to 0 on the next edge; clear wins over a simultaneous glitch increment.

Reset
REQ-025 reset assertion SHALL immediately, without clk, set all synchroniser flops and debounced to RESET_LEVEL, state to STABLE_<RESET_LEVEL>, counter 0, glitchCount 0, stable 1.
REQ-026 reset asserted mid-qualification SHALL abandon it with no debounced change and no glitch count.
REQ-027 after reset deasserts, the first qualification SHALL begin on the first edge where syncOut differs from RESET_LEVEL.

Verification
REQ-028 Defaults, reset released, rawIn 0->1 held: debounced rises on edge 18 after the change, stable low for edges 3..17, glitchCount stays 0.
REQ-029 Defaults, rawIn high for 5 cycles then back to 0: debounced stays 0, stable returns to 1, glitchCount = 1.
REQ-030 300 short pulses (3 cycles each, 20 cycles apart): glitchCount = 255; then clearGlitch together with one further glitch -> glitchCount = 0.
REQ-031 DEBOUNCE_CYCLES=1, SYNC_STAGES=3: rawIn 0->1 -> debounced rises on edge 4; stable never drops.
REQ-032 rawIn 1 held, enable low for 40 cycles -> debounced stays 0; enable high -> debounced rises 16 edges later; reset pulsed at cycle 8 of a qualification -> debounced 0, glitchCount 0.

Source files
------------

// File: rtl/signal_debouncer_if.sv
// rtl/signal_debouncer_if.sv - bundle of the debouncer's level inputs and qualified outputs
interface signal_debouncer_if;
  logic       rawIn;
  logic       enable;
  logic       clearGlitch;
  logic       debounced;
  logic       stable;
  logic [7:0] glitchCount;

  modport master (
    output rawIn,
    output enable,
    output clearGlitch,
    input  debounced,
    input  stable,
    input  glitchCount
  );

  modport slave (
    input  rawIn,
    input  enable,
    input  clearGlitch,
    output debounced,
    output stable,
    output glitchCount
  );
endinterface

// File: rtl/signal_debouncer.sv
// rtl/signal_debouncer.sv - synchronise a bouncy level, accept it after DEBOUNCE_CYCLES agreeing samples
module signal_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_LEVEL     = 0
) (
  input  logic              clk,
  input  logic              reset,
  signal_debouncer_if.slave bus
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] D_CNT   = CW'(DEBOUNCE_CYCLES);
  localparam logic          RST_LVL = (RESET_LEVEL != 0);

  // Bit 0 is the debounced level and bit 1 marks qualification, so both
  // outputs come straight off a flop with no decode.
  typedef enum logic [1:0] {
    STABLE_LOW   = 2'b00,
    STABLE_HIGH  = 2'b01,
    QUALIFY_HIGH = 2'b10,
    QUALIFY_LOW  = 2'b11
  } state_e;

  localparam state_e RST_STATE = RST_LVL ? STABLE_HIGH : STABLE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          count_inc;
  logic [7:0]             glitch_q, glitch_d;
  logic                   glitch_evt;
  logic                   deb;
  state_e                 hold_state;
  state_e                 flip_state;
  state_e                 qual_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rawIn};
    end
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign deb       = state_q[0];
  assign count_inc = count_q + CW'(1);

  assign hold_state = deb ? STABLE_HIGH  : STABLE_LOW;
  assign flip_state = deb ? STABLE_LOW   : STABLE_HIGH;
  assign qual_state = deb ? QUALIFY_LOW  : QUALIFY_HIGH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RST_STATE;
      count_q  <= '0;
      glitch_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    glitch_evt = 1'b0;
    if (!bus.enable) begin
      state_d = hold_state;
      count_d = '0;
    end else begin
      unique case (state_q)
        STABLE_LOW, STABLE_HIGH: begin
          if (sync_out != deb) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = flip_state;
              count_d = '0;
            end else begin
              state_d = qual_state;
              count_d = CW'(1);
            end
          end
        end
        QUALIFY_HIGH, QUALIFY_LOW: begin
          if (sync_out != deb) begin
            if (count_inc == D_CNT) begin
              state_d = flip_state;
              count_d = '0;
            end else begin
              count_d = count_inc;
            end
          end else begin
            state_d    = hold_state;
            count_d    = '0;
            glitch_evt = 1'b1;
          end
        end
        default: begin
          state_d = hold_state;
          count_d = '0;
        end
      endcase
    end
  end

  // Clear takes priority over a glitch landing on the same edge.
  always_comb begin
    glitch_d = glitch_q;
    if (bus.clearGlitch) begin
      glitch_d = 8'd0;
    end else if (glitch_evt && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  assign bus.debounced   = state_q[0];
  assign bus.stable      = ~state_q[1];
  assign bus.glitchCount = glitch_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// tb/tb_signal_debouncer.sv - vector table, corner sequences and random run against a level model
module tb_signal_debouncer;

  localparam int S_A = 2;
  localparam int D_A = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  signal_debouncer_if if_a ();
  signal_debouncer_if if_b ();

  signal_debouncer #(.SYNC_STAGES(S_A), .DEBOUNCE_CYCLES(D_A), .RESET_LEVEL(0)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (if_a)
  );

  signal_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(0)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (if_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_reset;
    logic       raw;
    logic       en;
    logic       clr;
    logic       deb;
    logic       stb;
    logic [7:0] gc;
  } vec_t;

  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: sync output is rawIn delayed S_A edges; a level is accepted
  // after D_A consecutive enabled edges disagreeing with the current level.
  logic       m_hist [S_A];
  logic       m_deb;
  int         m_run;
  int         m_glitch;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S_A; i++) m_hist[i] = 1'b0;
    m_deb    = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endtask

  task automatic model_edge(input logic raw, input logic en, input logic clr);
    logic s_old;
    bit   g;
    s_old = m_hist[S_A-1];
    g     = 0;
    if (!en) begin
      m_run = 0;
    end else if (s_old != m_deb) begin
      m_run++;
      if (m_run == D_A) begin
        m_deb = ~m_deb;
        m_run = 0;
      end
    end else begin
      if (m_run > 0) g = 1;
      m_run = 0;
    end
    if (clr) m_glitch = 0;
    else if (g && m_glitch < 255) m_glitch++;
    for (int i = S_A - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = raw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(if_a.rawIn, if_a.enable, if_a.clearGlitch);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic lvl;
    int   hold;

    if_a.rawIn = 1'b0; if_a.enable = 1'b1; if_a.clearGlitch = 1'b0;
    if_b.rawIn = 1'b0; if_b.enable = 1'b1; if_b.clearGlitch = 1'b0;
    model_reset();

    #1;
    chk("reset_deb_a", if_a.debounced, 0);
    chk("reset_stb_a", if_a.stable, 1);
    chk("reset_gc_a", if_a.glitchCount, 0);
    chk("reset_deb_b", if_b.debounced, 0);
    chk("reset_stb_b", if_b.stable, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean rise: accepted on edge S+D, stable low for edges 3..17.
    for (int k = 1; k <= 20; k++)
      vecs.push_back('{(k == 1), 1'b1, 1'b1, 1'b0, (k >= 18), !(k >= 3 && k <= 17), 8'd0});
    // Five-cycle pulse: qualification abandoned, one glitch.
    for (int k = 1; k <= 12; k++)
      vecs.push_back('{(k == 1), (k <= 5), 1'b1, 1'b0, 1'b0, !(k >= 3 && k <= 7), (k >= 8) ? 8'd1 : 8'd0});

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) do_reset();
      if_a.rawIn       = vecs[i].raw;
      if_a.enable      = vecs[i].en;
      if_a.clearGlitch = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_deb", i), if_a.debounced, vecs[i].deb);
      chk($sformatf("vec%0d_stb", i), if_a.stable, vecs[i].stb);
      chk($sformatf("vec%0d_gc", i), if_a.glitchCount, vecs[i].gc);
    end

    // Saturation with 300 short pulses, then clear against a coincident glitch.
    do_reset();
    if_a.rawIn = 1'b0;
    for (int p = 0; p < 300; p++) begin
      for (int c = 0; c < 20; c++) begin
        if_a.rawIn = (c < 3);
        step();
      end
      if (p == 99 || p == 254 || p == 299)
        chk($sformatf("sat_gc_p%0d", p), if_a.glitchCount, (p + 1 > 255) ? 255 : p + 1);
    end
    for (int c = 0; c < 5; c++) begin
      if_a.rawIn = (c < 3);
      step();
    end
    chk("sat_before_clr", if_a.glitchCount, 255);
    chk("sat_qualifying", if_a.stable, 0);
    if_a.clearGlitch = 1'b1;
    step();
    if_a.clearGlitch = 1'b0;
    chk("clr_wins_gc", if_a.glitchCount, 0);
    chk("clr_glitch_stb", if_a.stable, 1);

    // One-cycle qualification with three sync stages.
    do_reset();
    if_b.rawIn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("b_edge%0d_deb", k), if_b.debounced, (k >= 4));
      chk($sformatf("b_edge%0d_stb", k), if_b.stable, 1);
    end
    if_b.rawIn = 1'b0;

    // Enable held low freezes the level; re-enable starts a fresh qualification.
    do_reset();
    if_a.rawIn  = 1'b1;
    if_a.enable = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("en_low_deb", if_a.debounced, 0);
      if (k % 10 == 0) chk("en_low_stb", if_a.stable, 1);
    end
    if_a.enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1)  chk("en_rise_stb", if_a.stable, 0);
      if (k == 15) chk("en_rise_deb15", if_a.debounced, 0);
      if (k == 16) chk("en_rise_deb16", if_a.debounced, 1);
    end

    // Reset pulsed mid-qualification acts immediately and counts nothing.
    do_reset();
    chk("rst_async_deb", if_a.debounced, 0);
    for (int k = 1; k <= 10; k++) step();
    chk("midq_stb", if_a.stable, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midq_rst_deb", if_a.debounced, 0);
    chk("midq_rst_stb", if_a.stable, 1);
    chk("midq_rst_gc", if_a.glitchCount, 0);
    rst = 1'b0;
    if_a.rawIn = 1'b0;
    for (int k = 1; k <= 20; k++) step();
    chk("midq_after_deb", if_a.debounced, 0);
    chk("midq_after_gc", if_a.glitchCount, 0);

    // Random levels, enable drops and clears against the reference model.
    do_reset();
    hold = 0;
    lvl  = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold == 0) begin
        lvl  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 24);
      end
      hold--;
      if_a.rawIn       = lvl;
      if_a.enable      = ($urandom_range(0, 19) != 0);
      if_a.clearGlitch = ($urandom_range(0, 49) == 0);
      step();
      chk("rnd_deb", if_a.debounced, m_deb);
      chk("rnd_stb", if_a.stable, (m_run == 0));
      chk("rnd_gc", if_a.glitchCount, m_glitch);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
